output_packer: RTL

OUTPUT_PACKER -- requirements
Module: output_packer

---
 rtl/output_packer_pkg.sv | 29 ++
 rtl/output_packer_lane_quantizer.sv | 36 +++
 rtl/output_packer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/output_packer_pkg.sv
// Shared encodings for the output packer: precision codes, beats-per-word
// helper and the packer state type.
package output_packer_pkg;

    localparam int K_MAX = 4;

    typedef enum logic [1:0] {
        PREC_8B   = 2'd0,
        PREC_4B   = 2'd1,
        PREC_2B   = 2'd2,
        PREC_RSVD = 2'd3
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Reserved code 3 falls back to full 8-bit precision.
    function automatic int k_of(input logic [1:0] prec);
        case (prec)
            PREC_4B: return 2;
            PREC_2B: return 4;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/output_packer_lane_quantizer.sv
// One lane: optional signed clamp to P = ACT_WIDTH/K bits, then keep the low
// P bits (upper bits of q are always zero).
module lane_quantizer
    import output_packer_pkg::*;
#(
    parameter int ACT_WIDTH = 8
) (
    input  logic [1:0]           precision,
    input  logic                 sat_en,
    input  logic [ACT_WIDTH-1:0] lane,
    output logic [ACT_WIDTH-1:0] q
);

    int p_bits;
    int v;
    int hi;
    int lo;
    int c;
    logic [ACT_WIDTH-1:0] mask;

    always_comb begin
        p_bits = ACT_WIDTH / k_of(precision);
        v      = int'($signed(lane));
        hi     = (1 <<< (p_bits - 1)) - 1;
        lo     = -(1 <<< (p_bits - 1));
        c      = v;
        if (sat_en && (v > hi)) begin
            c = hi;
        end else if (sat_en && (v < lo)) begin
            c = lo;
        end
        mask = ACT_WIDTH'((1 << p_bits) - 1);
        q    = ACT_WIDTH'(c) & mask;
    end

endmodule

// File: rtl/output_packer.sv
// Packs K quantized PE-array beats into one N_DIM x ACT_WIDTH word, lane-wise
// or lane-grouped, with flush (zero-filled partial word) and clear.
//
// state   | meaning
// IDLE    | no group in progress, no word held
// FILL    | 1..K-1 beats buffered, output register empty
// HOLD    | packed word presented on out_data/out_valid
module output_packer
    import output_packer_pkg::*;
#(
    parameter int N_DIM     = 16,
    parameter int ACT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [1:0]                      precision,
    input  logic                            cnn_layout,
    input  logic                            sat_en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_DIM-1:0][ACT_WIDTH-1:0] in_data,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_DIM-1:0][ACT_WIDTH-1:0] out_data,
    output logic                            out_partial
);

    typedef logic [N_DIM-1:0][ACT_WIDTH-1:0] beat_t;

    state_e state_q, state_d;
    logic [1:0] cnt_q;
    logic [1:0] cfg_prec_q;
    logic       cfg_layout_q, cfg_sat_q;
    beat_t      beat_buf_q [K_MAX-1];

    logic [1:0] eff_prec;
    logic       eff_layout, eff_sat;
    int         k_eff;
    logic       first_beat, accept, complete, emit;
    beat_t      q_beat, pack_word;
    logic [K_MAX-1:0][N_DIM-1:0][ACT_WIDTH-1:0] beats;

    // Beat t of the group sits at bits [t*P +: P] of its destination lane.
    function automatic beat_t pack_fn(
        input logic [K_MAX-1:0][N_DIM-1:0][ACT_WIDTH-1:0] b,
        input logic lanewise,
        input int   k
    );
        beat_t w;
        int grp;
        int p;
        w   = '0;
        grp = N_DIM / k;
        p   = ACT_WIDTH / k;
        for (int m = 0; m < N_DIM; m++) begin
            for (int t = 0; t < K_MAX; t++) begin
                if (t < k) begin
                    if (lanewise)
                        w[m] = w[m] | (b[t][m] << (t * p));
                    else
                        w[m] = w[m] | (b[m / grp][k * (m % grp) + t] << (t * p));
                end
            end
        end
        return w;
    endfunction

    // Config is taken live on the first beat of a group, latched afterwards.
    assign first_beat = (cnt_q == 2'd0);
    assign eff_prec   = first_beat ? precision  : cfg_prec_q;
    assign eff_layout = first_beat ? cnn_layout : cfg_layout_q;
    assign eff_sat    = first_beat ? sat_en     : cfg_sat_q;
    assign k_eff      = k_of(eff_prec);

    assign accept   = in_valid && in_ready && !clear;
    assign complete = accept && (int'(cnt_q) == k_eff - 1);
    assign emit     = !clear && (complete || (flush && (state_q == ST_FILL)));

    for (genvar m = 0; m < N_DIM; m++) begin : g_lane
        lane_quantizer #(.ACT_WIDTH(ACT_WIDTH)) u_quant (
            .precision (eff_prec),
            .sat_en    (eff_sat),
            .lane      (in_data[m]),
            .q         (q_beat[m])
        );
    end

    always_comb begin
        beats = '0;
        for (int j = 0; j < K_MAX - 1; j++) begin
            if (j < int'(cnt_q)) beats[j] = beat_buf_q[j];
        end
        if (accept) beats[cnt_q] = q_beat;
        case (k_eff)
            2:       pack_word = pack_fn(beats, eff_layout, 2);
            4:       pack_word = pack_fn(beats, eff_layout, 4);
            default: pack_word = pack_fn(beats, eff_layout, 1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (emit) state_d = ST_HOLD;
                         else if (accept) state_d = ST_FILL;
                ST_FILL: if (emit) state_d = ST_HOLD;
                ST_HOLD: if (emit) state_d = ST_HOLD;
                         else if (accept) state_d = ST_FILL;
                         else if (out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == ST_HOLD);
        in_ready  = !(out_valid && !out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 2'd0;
            cfg_prec_q   <= 2'd0;
            cfg_layout_q <= 1'b0;
            cfg_sat_q    <= 1'b0;
            out_data     <= '0;
            out_partial  <= 1'b0;
            for (int j = 0; j < K_MAX - 1; j++) beat_buf_q[j] <= '0;
        end else if (clear) begin
            cnt_q       <= 2'd0;
            out_data    <= '0;
            out_partial <= 1'b0;
        end else begin
            if (accept && first_beat) begin
                cfg_prec_q   <= precision;
                cfg_layout_q <= cnn_layout;
                cfg_sat_q    <= sat_en;
            end
            if (emit) begin
                out_data    <= pack_word;
                out_partial <= !complete;
                cnt_q       <= 2'd0;
            end else if (accept) begin
                for (int j = 0; j < K_MAX - 1; j++) begin
                    if (cnt_q == 2'(j)) beat_buf_q[j] <= q_beat;
                end
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

endmodule
